// File: rtl/comparator_csr_master.sv
// Comparator CSR master.
// Turns configuration commands (CAT / MAXCOUNT / NMR) into single CSR writes.
// On a comparator interrupt it reads the exception, success and fail
// registers, clears the exception register, and reports the result as a
// one-cycle pulse. Every CSR access is guarded by a waitrequest timeout that
// abandons the sequence and raises a sticky error.
module comparator_csr_master #(
    parameter int CSR_ADDR_WIDTH = 6,
    parameter int OFF_EXC        = 0,
    parameter int OFF_SUCCESS    = 1,
    parameter int OFF_FAIL       = 2,
    parameter int OFF_MAXCOUNT   = 3,
    parameter int OFF_NMR        = 4,
    parameter int OFF_CAT        = 5,
    parameter int EXC_INT_BIT    = 0,
    parameter int EXC_EX_BIT     = 1,
    parameter int EXC_TASK_LSB   = 4,
    parameter int TIMEOUT        = 255
) (
    input  logic                      clk,
    input  logic                      reset_n,
    // command side
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_type,
    input  logic [3:0]                cmd_task_id,
    input  logic [1:0]                cmd_logical_core,
    input  logic [15:0]               cmd_data,
    // CSR master side
    output logic [CSR_ADDR_WIDTH-1:0] csr_address,
    output logic                      csr_read,
    output logic                      csr_write,
    output logic [31:0]               csr_writedata,
    input  logic [31:0]               csr_readdata,
    input  logic                      csr_waitrequest,
    input  logic                      irq,
    // result side
    output logic                      res_valid,
    output logic [3:0]                res_task_id,
    output logic                      res_mismatch,
    output logic [15:0]               res_success,
    output logic [31:0]               res_fail,
    output logic                      err_timeout,
    input  logic                      err_clear
);

    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_EXC      = CSR_ADDR_WIDTH'(OFF_EXC);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_SUCCESS  = CSR_ADDR_WIDTH'(OFF_SUCCESS);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_FAIL     = CSR_ADDR_WIDTH'(OFF_FAIL);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MAXCOUNT = CSR_ADDR_WIDTH'(OFF_MAXCOUNT);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_NMR      = CSR_ADDR_WIDTH'(OFF_NMR);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_CAT      = CSR_ADDR_WIDTH'(OFF_CAT);
    localparam logic [8:0]                TIMEOUT_C     = 9'(TIMEOUT);

    localparam logic [1:0] CMD_CAT      = 2'd0;
    localparam logic [1:0] CMD_MAXCOUNT = 2'd1;
    localparam logic [1:0] CMD_NMR      = 2'd2;
    localparam logic [1:0] CMD_RSVD     = 2'd3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD_WR  = 3'd1,
        RD_EXC  = 3'd2,
        RD_SUC  = 3'd3,
        RD_FAIL = 3'd4,
        CLR_EXC = 3'd5,
        RESULT  = 3'd6
    } state_t;

    // CSR word address targeted by a configuration command type.
    function automatic logic [CSR_ADDR_WIDTH-1:0] cmd_addr_f(input logic [1:0] t);
        logic [CSR_ADDR_WIDTH-1:0] a;
        case (t)
            CMD_CAT:      a = ADDR_CAT;
            CMD_MAXCOUNT: a = ADDR_MAXCOUNT;
            CMD_NMR:      a = ADDR_NMR;
            default:      a = ADDR_EXC;
        endcase
        return a;
    endfunction

    // Write word for a configuration command; unused bits are zero.
    function automatic logic [31:0] cmd_wdata_f(input logic [1:0]  t,
                                                input logic [3:0]  tid,
                                                input logic [1:0]  lcore,
                                                input logic [15:0] d);
        logic [31:0] w;
        w        = 32'd0;
        w[19:16] = tid;
        case (t)
            CMD_CAT: begin
                w[25:24] = lcore;
                w[3:0]   = d[3:0];
            end
            CMD_MAXCOUNT: w[15:0] = d;
            CMD_NMR:      w[0]    = d[0];
            default:      w       = 32'd0;
        endcase
        return w;
    endfunction

    state_t                    state_r;
    logic [1:0]                cmd_type_r;
    logic [3:0]                cmd_task_r;
    logic [1:0]                cmd_lcore_r;
    logic [15:0]               cmd_data_r;
    logic [CSR_ADDR_WIDTH-1:0] csr_address_r;
    logic                      csr_read_r;
    logic                      csr_write_r;
    logic [31:0]               csr_writedata_r;
    logic [8:0]                wait_cnt_r;
    logic [3:0]                exc_task_r;
    logic                      exc_mis_r;
    logic [15:0]               suc_r;
    logic [31:0]               fail_r;
    logic                      res_valid_r;
    logic [3:0]                res_task_id_r;
    logic                      res_mismatch_r;
    logic [15:0]               res_success_r;
    logic [31:0]               res_fail_r;
    logic                      err_timeout_r;

    logic                      strobe_s;
    logic [8:0]                wait_cnt_inc_s;
    logic                      timeout_s;
    logic [CSR_ADDR_WIDTH-1:0] acc_addr_s;
    logic                      acc_write_s;
    logic [31:0]               acc_wdata_s;
    state_t                    next_state_s;

    // Access bookkeeping: an access is in flight while a strobe is up.
    always_comb begin
        strobe_s       = csr_read_r | csr_write_r;
        wait_cnt_inc_s = wait_cnt_r + 9'd1;
        if (strobe_s && csr_waitrequest && (wait_cnt_inc_s >= TIMEOUT_C)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Per-state access description and successor state on completion.
    always_comb begin
        acc_addr_s   = ADDR_EXC;
        acc_write_s  = 1'b0;
        acc_wdata_s  = 32'd0;
        next_state_s = IDLE;
        case (state_r)
            CMD_WR: begin
                acc_addr_s   = cmd_addr_f(cmd_type_r);
                acc_write_s  = 1'b1;
                acc_wdata_s  = cmd_wdata_f(cmd_type_r, cmd_task_r, cmd_lcore_r, cmd_data_r);
                next_state_s = IDLE;
            end
            RD_EXC: begin
                acc_addr_s   = ADDR_EXC;
                // A spurious interrupt (no pending flag) ends the sequence here.
                next_state_s = csr_readdata[EXC_INT_BIT] ? RD_SUC : IDLE;
            end
            RD_SUC: begin
                acc_addr_s   = ADDR_SUCCESS;
                next_state_s = RD_FAIL;
            end
            RD_FAIL: begin
                acc_addr_s   = ADDR_FAIL;
                next_state_s = CLR_EXC;
            end
            CLR_EXC: begin
                acc_addr_s   = ADDR_EXC;
                acc_write_s  = 1'b1;
                acc_wdata_s  = 32'd0;
                next_state_s = RESULT;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Interrupts take priority; only an idle master with no pending irq takes commands.
    assign cmd_ready = (state_r == IDLE) && !irq;

    // Main sequencer: command capture, CSR access handshake, result and error registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= IDLE;
            cmd_type_r      <= 2'd0;
            cmd_task_r      <= 4'd0;
            cmd_lcore_r     <= 2'd0;
            cmd_data_r      <= 16'd0;
            csr_address_r   <= '0;
            csr_read_r      <= 1'b0;
            csr_write_r     <= 1'b0;
            csr_writedata_r <= 32'd0;
            wait_cnt_r      <= 9'd0;
            exc_task_r      <= 4'd0;
            exc_mis_r       <= 1'b0;
            suc_r           <= 16'd0;
            fail_r          <= 32'd0;
            res_valid_r     <= 1'b0;
            res_task_id_r   <= 4'd0;
            res_mismatch_r  <= 1'b0;
            res_success_r   <= 16'd0;
            res_fail_r      <= 32'd0;
            err_timeout_r   <= 1'b0;
        end else begin
            res_valid_r <= 1'b0;
            // Clear first so that a timeout in the same cycle overrides it.
            if (err_clear) begin
                err_timeout_r <= 1'b0;
            end else begin
                err_timeout_r <= err_timeout_r;
            end

            case (state_r)
                IDLE: begin
                    if (irq) begin
                        state_r <= RD_EXC;
                    end else if (cmd_valid) begin
                        if (cmd_type != CMD_RSVD) begin
                            cmd_type_r  <= cmd_type;
                            cmd_task_r  <= cmd_task_id;
                            cmd_lcore_r <= cmd_logical_core;
                            cmd_data_r  <= cmd_data;
                            state_r     <= CMD_WR;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end

                CMD_WR, RD_EXC, RD_SUC, RD_FAIL, CLR_EXC: begin
                    if (!strobe_s) begin
                        // Entering with strobes low leaves an idle gap between accesses.
                        csr_address_r   <= acc_addr_s;
                        csr_read_r      <= !acc_write_s;
                        csr_write_r     <= acc_write_s;
                        csr_writedata_r <= acc_wdata_s;
                        wait_cnt_r      <= 9'd0;
                    end else if (timeout_s) begin
                        csr_read_r      <= 1'b0;
                        csr_write_r     <= 1'b0;
                        csr_address_r   <= '0;
                        csr_writedata_r <= 32'd0;
                        wait_cnt_r      <= wait_cnt_inc_s;
                        err_timeout_r   <= 1'b1;
                        state_r         <= IDLE;
                    end else if (!csr_waitrequest) begin
                        csr_read_r      <= 1'b0;
                        csr_write_r     <= 1'b0;
                        csr_address_r   <= '0;
                        csr_writedata_r <= 32'd0;
                        state_r         <= next_state_s;
                        case (state_r)
                            RD_EXC: begin
                                exc_task_r <= csr_readdata[EXC_TASK_LSB+3:EXC_TASK_LSB];
                                exc_mis_r  <= csr_readdata[EXC_EX_BIT];
                            end
                            RD_SUC:  suc_r  <= csr_readdata[15:0];
                            RD_FAIL: fail_r <= csr_readdata;
                            default: begin
                                fail_r <= fail_r;
                            end
                        endcase
                    end else begin
                        wait_cnt_r <= wait_cnt_inc_s;
                    end
                end

                RESULT: begin
                    res_valid_r    <= 1'b1;
                    res_task_id_r  <= exc_task_r;
                    res_mismatch_r <= exc_mis_r;
                    res_success_r  <= suc_r;
                    res_fail_r     <= fail_r;
                    state_r        <= IDLE;
                end

                default: begin
                    csr_read_r  <= 1'b0;
                    csr_write_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign csr_address   = csr_address_r;
    assign csr_read      = csr_read_r;
    assign csr_write     = csr_write_r;
    assign csr_writedata = csr_writedata_r;
    assign res_valid     = res_valid_r;
    assign res_task_id   = res_task_id_r;
    assign res_mismatch  = res_mismatch_r;
    assign res_success   = res_success_r;
    assign res_fail      = res_fail_r;
    assign err_timeout   = err_timeout_r;

endmodule

// File: tb/tb_comparator_csr_master.sv
// Scoreboard bench for comparator_csr_master: directed stimulus pushes the
// expected CSR accesses and results into a queue; a monitor pops and compares
// each completed access and each result pulse.
module tb_comparator_csr_master;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [3:0]  cmd_task_id;
    logic [1:0]  cmd_logical_core;
    logic [15:0] cmd_data;
    logic [5:0]  csr_address;
    logic        csr_read;
    logic        csr_write;
    logic [31:0] csr_writedata;
    logic [31:0] csr_readdata;
    logic        csr_waitrequest;
    logic        irq;
    logic        res_valid;
    logic [3:0]  res_task_id;
    logic        res_mismatch;
    logic [15:0] res_success;
    logic [31:0] res_fail;
    logic        err_timeout;
    logic        err_clear;

    comparator_csr_master dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_type         (cmd_type),
        .cmd_task_id      (cmd_task_id),
        .cmd_logical_core (cmd_logical_core),
        .cmd_data         (cmd_data),
        .csr_address      (csr_address),
        .csr_read         (csr_read),
        .csr_write        (csr_write),
        .csr_writedata    (csr_writedata),
        .csr_readdata     (csr_readdata),
        .csr_waitrequest  (csr_waitrequest),
        .irq              (irq),
        .res_valid        (res_valid),
        .res_task_id      (res_task_id),
        .res_mismatch     (res_mismatch),
        .res_success      (res_success),
        .res_fail         (res_fail),
        .err_timeout      (err_timeout),
        .err_clear        (err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 read, 1 write, 2 result
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  tid;
        logic        mis;
        logic [15:0] suc;
        logic [31:0] fail;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [0:63];
    int          delay = 0;
    bit          stuck = 1'b0;
    int          wcnt = 0;
    int          irq_raise_n = 0;
    int          irq_ack_n = 0;
    bit          gap_pending = 1'b0;

    assign irq = (irq_raise_n != irq_ack_n);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic void push_rd(input logic [5:0] a);
        exp_t e;
        e = '{kind: 0, addr: a, data: 32'd0, tid: 4'd0, mis: 1'b0, suc: 16'd0, fail: 32'd0};
        exp_q.push_back(e);
    endfunction

    function automatic void push_wr(input logic [5:0] a, input logic [31:0] d);
        exp_t e;
        e = '{kind: 1, addr: a, data: d, tid: 4'd0, mis: 1'b0, suc: 16'd0, fail: 32'd0};
        exp_q.push_back(e);
    endfunction

    function automatic void push_res(input logic [3:0] t, input logic m,
                                     input logic [15:0] s, input logic [31:0] f);
        exp_t e;
        e = '{kind: 2, addr: 6'd0, data: 32'd0, tid: t, mis: m, suc: s, fail: f};
        exp_q.push_back(e);
    endfunction

    // CSR slave: waitrequest high for 'delay' cycles per access (forever when stuck).
    always @(posedge clk) begin
        #2;
        if (csr_read || csr_write) begin
            if (stuck || (wcnt < delay)) begin
                csr_waitrequest = 1'b1;
                wcnt++;
            end else begin
                csr_waitrequest = 1'b0;
                if (csr_read) csr_readdata = mem[csr_address];
            end
        end else begin
            csr_waitrequest = 1'b0;
            wcnt = 0;
        end
    end

    // Comparator model: irq drops when the exception register is cleared or reads as empty.
    always @(negedge clk) begin
        if (reset_n && !csr_waitrequest && csr_address == 6'd0) begin
            if (csr_write) irq_ack_n = irq_raise_n;
            else if (csr_read && !csr_readdata[0]) irq_ack_n = irq_raise_n;
        end
    end

    // Monitor: compare completed accesses and result pulses against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            gap_pending = 1'b0;
        end else begin
            if (gap_pending) check("gap_after_access", {30'd0, csr_read, csr_write}, 32'd0);
            gap_pending = 1'b0;
            if ((csr_read || csr_write) && !csr_waitrequest) begin
                gap_pending = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_access", {26'd0, csr_address}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("access_kind", {31'd0, csr_write}, (e.kind == 1) ? 32'd1 : 32'd0);
                    check("access_addr", {26'd0, csr_address}, {26'd0, e.addr});
                    if (e.kind == 1) check("access_wdata", csr_writedata, e.data);
                end
            end
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_res_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_kind", 32'(e.kind), 32'd2);
                    check("res_task_id", {28'd0, res_task_id}, {28'd0, e.tid});
                    check("res_mismatch", {31'd0, res_mismatch}, {31'd0, e.mis});
                    check("res_success", {16'd0, res_success}, {16'd0, e.suc});
                    check("res_fail", res_fail, e.fail);
                end
            end
        end
    end

    task automatic send_cmd(input logic [1:0] t, input logic [3:0] tid,
                            input logic [1:0] lc, input logic [15:0] d);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_type = t; cmd_task_id = tid;
        cmd_logical_core = lc; cmd_data = d;
        for (int i = 0; i < 400; i++) begin
            #1;
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("cmd_accepted", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check(nm, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic init_mem(input logic [31:0] e, input logic [31:0] s, input logic [31:0] f);
        mem[0] = e; mem[1] = s; mem[2] = f;
    endtask

    initial begin
        int hi;
        bit seen;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_type = 2'd0; cmd_task_id = 4'd0;
        cmd_logical_core = 2'd0; cmd_data = 16'd0; err_clear = 1'b0;
        csr_readdata = 32'd0; csr_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_csr_read", {31'd0, csr_read}, 32'd0);
        check("rst_csr_write", {31'd0, csr_write}, 32'd0);
        check("rst_csr_address", {26'd0, csr_address}, 32'd0);
        check("rst_csr_writedata", csr_writedata, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_fail", res_fail, 32'd0);
        check("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // CAT write, two wait cycles
        delay = 2;
        push_wr(6'd5, 32'h0205_0003);
        send_cmd(2'd0, 4'd5, 2'd2, 16'h0003);
        drain("drain_cat");

        // MAXCOUNT write, no wait
        delay = 0;
        push_wr(6'd3, 32'h0003_1234);
        send_cmd(2'd1, 4'd3, 2'd0, 16'h1234);
        drain("drain_maxcount");

        // NMR write keeps only bit 0 of the data
        delay = 1;
        push_wr(6'd4, 32'h000A_0001);
        send_cmd(2'd2, 4'hA, 2'd3, 16'hFFFF);
        drain("drain_nmr");

        // reserved command is accepted and produces no access
        send_cmd(2'd3, 4'hF, 2'd3, 16'hFFFF);
        drain("drain_reserved");

        // interrupt sequence, no mismatch
        init_mem(32'h0000_0071, 32'h0000_0080, 32'hFFFF_3FFF);
        push_rd(6'd0); push_rd(6'd1); push_rd(6'd2); push_wr(6'd0, 32'd0);
        push_res(4'd7, 1'b0, 16'h0080, 32'hFFFF_3FFF);
        @(negedge clk); irq_raise_n = irq_ack_n + 1;
        drain("drain_irq_a");

        // interrupt sequence with mismatch, slow slave
        delay = 3;
        init_mem(32'h0000_00C3, 32'h1234_5678, 32'h0000_0001);
        push_rd(6'd0); push_rd(6'd1); push_rd(6'd2); push_wr(6'd0, 32'd0);
        push_res(4'hC, 1'b1, 16'h5678, 32'h0000_0001);
        @(negedge clk); irq_raise_n = irq_ack_n + 1;
        drain("drain_irq_b");

        // irq and command together: interrupt first, then the command
        delay = 1;
        init_mem(32'h0000_0053, 32'hAAAA_0001, 32'h8000_0000);
        push_rd(6'd0); push_rd(6'd1); push_rd(6'd2); push_wr(6'd0, 32'd0);
        push_res(4'd5, 1'b1, 16'h0001, 32'h8000_0000);
        push_wr(6'd5, 32'h0101_0009);
        @(negedge clk);
        irq_raise_n = irq_ack_n + 1;
        cmd_valid = 1'b1; cmd_type = 2'd0; cmd_task_id = 4'd1;
        cmd_logical_core = 2'd1; cmd_data = 16'h0009;
        #1 check("irq_blocks_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        send_cmd(2'd0, 4'd1, 2'd1, 16'h0009);
        drain("drain_irq_cmd");

        // spurious interrupt: one read, then idle; results keep their value
        init_mem(32'h0000_0070, 32'h0000_1111, 32'h2222_2222);
        push_rd(6'd0);
        @(negedge clk); irq_raise_n = irq_ack_n + 1;
        drain("drain_spurious");
        check("spurious_idle_ready", {31'd0, cmd_ready}, 32'd1);
        check("res_hold_task", {28'd0, res_task_id}, 32'd5);
        check("res_hold_fail", res_fail, 32'h8000_0000);

        // timeout on a stuck NMR write
        stuck = 1'b1;
        send_cmd(2'd2, 4'd6, 2'd0, 16'h0001);
        hi = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (csr_write) hi++;
            else if (hi > 0) break;
        end
        check("timeout_strobe_cycles", 32'(hi), 32'd255);
        check("timeout_err_set", {31'd0, err_timeout}, 32'd1);
        check("timeout_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        stuck = 1'b0;
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("err_clear", {31'd0, err_timeout}, 32'd0);
        drain("drain_timeout");

        // reset in the middle of the fail-register read
        delay = 5;
        init_mem(32'h0000_0091, 32'h0000_0042, 32'h0000_0024);
        push_rd(6'd0); push_rd(6'd1);
        @(negedge clk); irq_raise_n = irq_ack_n + 1;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (csr_read && csr_address == 6'd2) begin
                seen = 1'b1;
                break;
            end
        end
        check("reached_rd_fail", {31'd0, seen}, 32'd1);
        #1 reset_n = 1'b0;
        irq_raise_n = irq_ack_n;
        #1;
        check("midrst_csr_read", {31'd0, csr_read}, 32'd0);
        check("midrst_csr_address", {26'd0, csr_address}, 32'd0);
        check("midrst_res_task", {28'd0, res_task_id}, 32'd0);
        check("midrst_res_success", {16'd0, res_success}, 32'd0);
        check("midrst_res_fail", res_fail, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("post_rst_no_read", {31'd0, csr_read}, 32'd0);
        check("post_rst_queue", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
